// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the receive/transmit state encoding.
// Pure declarations; no timing or flow-control behaviour lives here.
package uart_pkg;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake and status bundle between uart_rx (master) and its consumer (slave).
// Byte transfers on valid_o & ready_i; error/overrun flags are single-cycle pulses.
interface uart_rx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] rx_data_o;
   logic                 valid_o;
   logic                 ready_i;
   logic                 frame_err_o;
   logic                 overrun_o;
   logic                 busy_o;

   modport master (
      output rx_data_o,
      output valid_o,
      input  ready_i,
      output frame_err_o,
      output overrun_o,
      output busy_o
   );

   modport slave (
      input  rx_data_o,
      input  valid_o,
      output ready_i,
      input  frame_err_o,
      input  overrun_o,
      input  busy_o
   );

endinterface

// File: rtl/uart_sync.sv
// STAGES-deep input synchronizer, output lags input by STAGES clocks.
// Resets to 1 so an idle-high line never looks like a start bit; no backpressure.
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling; valid_o rises ~9.5 bit-times + SYNC_STAGES + 1 clocks after the start edge.
// A byte is held until ready_i; a good frame arriving while still held is dropped with an overrun pulse.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic      clk_i,
   input  logic      reset_i,
   input  logic      rx_i,
   uart_rx_if.master rx_if
);

   localparam int CW   = $clog2(CLK_PER_BIT) + 1;
   localparam int HALF = CLK_PER_BIT / 2;
   localparam int BW   = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 ferr_q;
   logic                 ovr_q;
   logic                 load;
   logic                 ferr_set;
   logic                 ovr_set;
   logic                 accept;
   logic                 rx_s;

   uart_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (rx_i),
      .q_o     (rx_s)
   );

   assign accept = valid_q & rx_if.ready_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      load     = 1'b0;
      ferr_set = 1'b0;
      ovr_set  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = START;
            end
         end

         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  bit_d   = '0;
               end
            end
         end

         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + BW'(1);
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
               end
            end
         end

         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (!rx_s) begin
                  ferr_set = 1'b1;
                  state_d  = WAIT_IDLE;
               end else begin
                  // Returning to IDLE mid-stop-bit lets a zero-gap next frame be caught.
                  state_d = IDLE;
                  if (!valid_q || rx_if.ready_i) begin
                     load = 1'b1;
                  end else begin
                     ovr_set = 1'b1;
                  end
               end
            end
         end

         WAIT_IDLE: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         ferr_q  <= ferr_set;
         ovr_q   <= ovr_set;
         // A load in the same cycle as an accept keeps valid high with the new byte.
         if (load) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_if.rx_data_o   = data_q;
   assign rx_if.valid_o     = valid_q;
   assign rx_if.frame_err_o = ferr_q;
   assign rx_if.overrun_o   = ovr_q;
   assign rx_if.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLK_PER_BIT=8: vector table, corner sequences, random frames vs a byte-queue model.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB  = 8;
   localparam int SYNC = 2;
   localparam int HALF = CPB / 2;

   logic clk_i = 1'b0;
   logic reset_i;
   logic rx_i;

   always #5 clk_i = ~clk_i;

   uart_rx_if rx_if ();

   uart_rx #(
      .CLK_PER_BIT (CPB),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .rx_i    (rx_i),
      .rx_if   (rx_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] acc_q[$];
   int   ferr_n    = 0;
   int   ovr_n     = 0;
   int   busy_fall = 0;
   int   busy_rise = 0;
   int   cyc       = 0;
   int   rise_cyc  = 0;
   int   start_cyc = 0;
   logic vld_prev  = 1'b0;
   logic busy_prev = 1'b0;

   // Observer: an accept seen here takes effect on the next rising edge.
   always @(negedge clk_i) begin
      cyc = cyc + 1;
      if (rx_if.valid_o && !vld_prev) rise_cyc = cyc;
      if (rx_if.valid_o && rx_if.ready_i) acc_q.push_back(rx_if.rx_data_o);
      if (rx_if.frame_err_o) ferr_n = ferr_n + 1;
      if (rx_if.overrun_o) ovr_n = ovr_n + 1;
      if (busy_prev && !rx_if.busy_o) busy_fall = busy_fall + 1;
      if (!busy_prev && rx_if.busy_o) busy_rise = busy_rise + 1;
      vld_prev  = rx_if.valid_o;
      busy_prev = rx_if.busy_o;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx_i      = 1'b0;
      start_cyc = cyc;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (CPB) tick();
      end
      rx_i = stop;
      repeat (CPB) tick();
      rx_i = 1'b1;
   endtask

   task automatic clear_obs();
      acc_q.delete();
      ferr_n    = 0;
      ovr_n     = 0;
      busy_fall = 0;
      busy_rise = 0;
   endtask

   typedef struct {
      logic [7:0] dat;
      logic       stop;
      logic       rdy;
      int         exp_acc;
      logic [7:0] exp_first;
      logic [7:0] exp_last;
      logic       exp_vld;
      logic [7:0] exp_hold;
      int         exp_ferr;
      int         exp_ovr;
   } vec_t;

   vec_t vecs[9];

   logic [7:0] exp_q[$];
   int         exp_ferr;

   initial begin
      // Vectors run in order; a byte left pending by one row is accepted by the next ready row.
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 8'hA5, 1'b0, 8'h00, 0, 0};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 8'h00, 1'b0, 8'h00, 0, 0};
      vecs[2] = '{8'hFF, 1'b0, 1'b1, 0, 8'h00, 8'h00, 1'b0, 8'h00, 1, 0};
      vecs[3] = '{8'h3C, 1'b1, 1'b1, 1, 8'h3C, 8'h3C, 1'b0, 8'h00, 0, 0};
      vecs[4] = '{8'h55, 1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b1, 8'h55, 0, 0};
      vecs[5] = '{8'h12, 1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b1, 8'h55, 0, 1};
      vecs[6] = '{8'h81, 1'b1, 1'b1, 2, 8'h55, 8'h81, 1'b0, 8'h00, 0, 0};
      vecs[7] = '{8'hC3, 1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b1, 8'hC3, 0, 0};
      vecs[8] = '{8'h7E, 1'b1, 1'b1, 2, 8'hC3, 8'h7E, 1'b0, 8'h00, 0, 0};

      reset_i       = 1'b1;
      rx_i          = 1'b1;
      rx_if.ready_i = 1'b0;
      repeat (3) tick();
      check("reset data",  32'(rx_if.rx_data_o),   32'h00);
      check("reset valid", 32'(rx_if.valid_o),     32'h0);
      check("reset ferr",  32'(rx_if.frame_err_o), 32'h0);
      check("reset ovr",   32'(rx_if.overrun_o),   32'h0);
      check("reset busy",  32'(rx_if.busy_o),      32'h0);
      reset_i = 1'b0;
      idle(4);
      check("post-reset busy", 32'(rx_if.busy_o), 32'h0);

      for (int i = 0; i < 9; i++) begin
         rx_if.ready_i = vecs[i].rdy;
         clear_obs();
         send_frame(vecs[i].dat, vecs[i].stop);
         idle(2 * CPB);
         check($sformatf("v%0d acc_n", i), 32'(acc_q.size()), 32'(vecs[i].exp_acc));
         if (acc_q.size() > 0) begin
            check($sformatf("v%0d first", i), 32'(acc_q[0]), 32'(vecs[i].exp_first));
            check($sformatf("v%0d last", i),  32'(acc_q[$]), 32'(vecs[i].exp_last));
         end
         check($sformatf("v%0d valid", i), 32'(rx_if.valid_o), 32'(vecs[i].exp_vld));
         if (vecs[i].exp_vld) begin
            check($sformatf("v%0d hold", i), 32'(rx_if.rx_data_o), 32'(vecs[i].exp_hold));
         end
         check($sformatf("v%0d ferr", i), 32'(ferr_n), 32'(vecs[i].exp_ferr));
         check($sformatf("v%0d ovr", i),  32'(ovr_n),  32'(vecs[i].exp_ovr));
         check($sformatf("v%0d busy", i), 32'(rx_if.busy_o), 32'h0);
      end

      // Latency: sync + idle detect + half bit + 9 bits, seen on the following falling edge.
      rx_if.ready_i = 1'b1;
      clear_obs();
      send_frame(8'hA5, 1'b1);
      idle(2 * CPB);
      check("latency", 32'(rise_cyc - start_cyc), 32'(SYNC + 1 + HALF + 9 * CPB + 1));
      check("latency data", 32'(acc_q.size() == 1 && acc_q[0] == 8'hA5), 32'h1);

      clear_obs();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h3C, 1'b1);
      idle(2 * CPB);
      check("b2b count", 32'(acc_q.size()), 32'd3);
      if (acc_q.size() == 3) begin
         check("b2b d0", 32'(acc_q[0]), 32'h00);
         check("b2b d1", 32'(acc_q[1]), 32'hFF);
         check("b2b d2", 32'(acc_q[2]), 32'h3C);
      end
      check("b2b busy falls", 32'(busy_fall), 32'd3);
      check("b2b ferr", 32'(ferr_n), 32'd0);

      // Accept and load coincide on the stop-sample edge.
      rx_if.ready_i = 1'b0;
      send_frame(8'h11, 1'b1);
      idle(CPB);
      clear_obs();
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (SYNC + 1 + HALF + 9 * CPB - 1) tick();
            rx_if.ready_i = 1'b1;
            tick();
            rx_if.ready_i = 1'b0;
         end
      join
      idle(CPB);
      check("coincide ovr", 32'(ovr_n), 32'd0);
      check("coincide acc_n", 32'(acc_q.size()), 32'd1);
      if (acc_q.size() > 0) check("coincide old", 32'(acc_q[0]), 32'h11);
      check("coincide valid", 32'(rx_if.valid_o), 32'h1);
      check("coincide data", 32'(rx_if.rx_data_o), 32'h22);
      rx_if.ready_i = 1'b1;
      idle(4);
      check("coincide drain", 32'(acc_q.size() == 2 && acc_q[1] == 8'h22), 32'h1);

      clear_obs();
      send_frame(8'h5A, 1'b0);
      rx_i = 1'b0;
      repeat (30) tick();
      check("break busy", 32'(rx_if.busy_o), 32'h1);
      check("break ferr", 32'(ferr_n), 32'd1);
      check("break acc_n", 32'(acc_q.size()), 32'd0);
      check("break valid", 32'(rx_if.valid_o), 32'h0);
      check("break rises", 32'(busy_rise), 32'd1);
      idle(2 * CPB);
      check("break recover busy", 32'(rx_if.busy_o), 32'h0);
      send_frame(8'h81, 1'b1);
      idle(2 * CPB);
      check("break next acc_n", 32'(acc_q.size()), 32'd1);
      if (acc_q.size() > 0) check("break next data", 32'(acc_q[0]), 32'h81);
      check("break next ferr", 32'(ferr_n), 32'd1);

      clear_obs();
      rx_i = 1'b0;
      repeat (3) tick();
      idle(2 * CPB);
      check("glitch acc_n", 32'(acc_q.size()), 32'd0);
      check("glitch ferr", 32'(ferr_n), 32'd0);
      check("glitch valid", 32'(rx_if.valid_o), 32'h0);
      check("glitch busy", 32'(rx_if.busy_o), 32'h0);
      check("glitch rises", 32'(busy_rise), 32'd1);

      // Reset during bit 4 of 0xF0 with a byte still pending.
      rx_if.ready_i = 1'b0;
      send_frame(8'h3C, 1'b1);
      idle(CPB);
      check("pre-reset pending", 32'(rx_if.valid_o), 32'h1);
      rx_i = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 4; i++) begin
         rx_i = 1'b0;
         repeat (CPB) tick();
      end
      rx_i = 1'b1;
      repeat (3) tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check("midreset valid", 32'(rx_if.valid_o), 32'h0);
      check("midreset data", 32'(rx_if.rx_data_o), 32'h00);
      check("midreset busy", 32'(rx_if.busy_o), 32'h0);
      idle(5 * CPB);
      check("midreset quiet", 32'(rx_if.busy_o | rx_if.valid_o), 32'h0);
      rx_if.ready_i = 1'b1;
      clear_obs();
      send_frame(8'h0F, 1'b1);
      idle(2 * CPB);
      check("midreset next acc_n", 32'(acc_q.size()), 32'd1);
      if (acc_q.size() > 0) check("midreset next data", 32'(acc_q[0]), 32'h0F);

      // Random frames: every good stop delivers its byte in order, every bad stop one frame error.
      clear_obs();
      exp_q.delete();
      exp_ferr = 0;
      begin
         logic       prev_bad;
         logic [7:0] b;
         logic       stop;
         int         gap;
         prev_bad = 1'b0;
         for (int n = 0; n < 40; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            gap  = $urandom_range(0, 2);
            if (prev_bad && gap == 0) gap = 1;
            idle(gap * CPB);
            send_frame(b, stop);
            if (stop) exp_q.push_back(b);
            else exp_ferr++;
            prev_bad = !stop;
         end
      end
      idle(2 * CPB);
      check("rand count", 32'(acc_q.size()), 32'(exp_q.size()));
      check("rand ferr", 32'(ferr_n), 32'(exp_ferr));
      check("rand ovr", 32'(ovr_n), 32'd0);
      for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
         check($sformatf("rand byte %0d", i), 32'(acc_q[i]), 32'(exp_q[i]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
